// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART byte FIFO.
// Parents that build UART buffers import these so every instance sizes the same way.
package uart_fifo_pkg;

  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_DATA_W = 8;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the UART FIFO: one write port and one registered read port.
// Only the output register is reset, so a pop can never expose an unwritten location's X.
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // q only moves on an accepted pop; otherwise it keeps the last popped word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO between the UART engine and the CPU bus.
// Pointer and occupancy control live here; storage is in uart_fifo_ram.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  output logic              wrfull,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              rdempty,
  output logic [AW:0]       usedw
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  // Flags decode the registered count, so reset forces empty immediately.
  assign wrfull  = (usedw == FULL_COUNT);
  assign rdempty = (usedw == '0);
  assign wr_ok   = wrreq & ~wrfull;
  assign rd_ok   = rdreq & ~rdempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      usedw <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + (AW + 1)'(1);
        2'b01:   usedw <= usedw - (AW + 1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (data),
    .re    (rd_ok),
    .raddr (rptr),
    .q     (q)
  );

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo at DATA_W=8, DEPTH=16.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_uart_fifo;

  logic       clk;
  logic       rst_n;
  logic       wrreq;
  logic [7:0] data;
  logic       wrfull;
  logic       rdreq;
  logic [7:0] q;
  logic       rdempty;
  logic [4:0] usedw;

  int checks;
  int errors;

  uart_fifo #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrreq   (wrreq),
    .data    (data),
    .wrfull  (wrfull),
    .rdreq   (rdreq),
    .q       (q),
    .rdempty (rdempty),
    .usedw   (usedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    wrreq = wr;
    data  = d;
    rdreq = rd;
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdempty !== 1'b1 || wrfull !== 1'b0 || usedw !== 5'd0 || q !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: rdempty=%b wrfull=%b usedw=%0d q=%h, expected 1 0 0 00",
               rdempty, wrfull, usedw, q);
    end
    rst_n = 1'b1;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (q !== 8'h11 || usedw !== 5'd1) begin
      errors++;
      $display("[TB] FAIL pre_reset_pop: q=%h usedw=%0d, expected 11 1", q, usedw);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdempty !== 1'b1 || usedw !== 5'd0 || q !== 8'h00 || wrfull !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: rdempty=%b usedw=%0d q=%h wrfull=%b, expected 1 0 00 0",
               rdempty, usedw, q, wrfull);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h41;
    exp_q[1] = 8'h42;
    exp_q[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, exp_q[i], 1'b0);
      checks++;
      if (usedw !== 5'(i + 1) || rdempty !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_push%0d: usedw=%0d rdempty=%b, expected %0d 0",
                 i, usedw, rdempty, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== exp_q[i] || usedw !== 5'(2 - i)) begin
        errors++;
        $display("[TB] FAIL basic_pop%0d: q=%h usedw=%0d, expected %h %0d",
                 i, q, usedw, exp_q[i], 2 - i);
      end
    end
    checks++;
    if (rdempty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_empty: rdempty=%b, expected 1", rdempty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
    end
    checks++;
    if (wrfull !== 1'b1 || usedw !== 5'd16) begin
      errors++;
      $display("[TB] FAIL fill_full: wrfull=%b usedw=%0d, expected 1 16", wrfull, usedw);
    end
    step(1'b1, 8'hFF, 1'b0);
    checks++;
    if (wrfull !== 1'b1 || usedw !== 5'd16) begin
      errors++;
      $display("[TB] FAIL fill_overflow: wrfull=%b usedw=%0d, expected 1 16", wrfull, usedw);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== 8'(i) || usedw !== 5'(15 - i)) begin
        errors++;
        $display("[TB] FAIL fill_drain%0d: q=%h usedw=%0d, expected %h %0d",
                 i, q, usedw, 8'(i), 15 - i);
      end
    end
    checks++;
    if (rdempty !== 1'b1 || wrfull !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_end: rdempty=%b wrfull=%b, expected 1 0", rdempty, wrfull);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== 8'h0F || usedw !== 5'd0 || rdempty !== 1'b1) begin
        errors++;
        $display("[TB] FAIL underflow%0d: q=%h usedw=%0d rdempty=%b, expected 0f 0 1",
                 i, q, usedw, rdempty);
      end
    end
    step(1'b1, 8'h55, 1'b0);
    checks++;
    if (usedw !== 5'd1 || q !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL underflow_push: usedw=%0d q=%h, expected 1 0f", usedw, q);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (q !== 8'h55 || usedw !== 5'd0) begin
      errors++;
      $display("[TB] FAIL underflow_pop: q=%h usedw=%0d, expected 55 0", q, usedw);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
    end
    step(1'b1, 8'h15, 1'b1);
    checks++;
    if (usedw !== 5'd5 || q !== 8'h10) begin
      errors++;
      $display("[TB] FAIL simul_mid: usedw=%0d q=%h, expected 5 10", usedw, q);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== 8'(8'h11 + i)) begin
        errors++;
        $display("[TB] FAIL simul_order%0d: q=%h, expected %h", i, q, 8'(8'h11 + i));
      end
    end
    step(1'b1, 8'h20, 1'b1);
    checks++;
    if (usedw !== 5'd1 || q !== 8'h15 || rdempty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_empty: usedw=%0d q=%h rdempty=%b, expected 1 15 0",
               usedw, q, rdempty);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (q !== 8'h20 || usedw !== 5'd0) begin
      errors++;
      $display("[TB] FAIL simul_empty_pop: q=%h usedw=%0d, expected 20 0", q, usedw);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0);
    end
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if (usedw !== 5'd15 || q !== 8'h30 || wrfull !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_full: usedw=%0d q=%h wrfull=%b, expected 15 30 0",
               usedw, q, wrfull);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== 8'(8'h31 + i)) begin
        errors++;
        $display("[TB] FAIL simul_full_drain%0d: q=%h, expected %h", i, q, 8'(8'h31 + i));
      end
    end
    checks++;
    if (rdempty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_full_end: rdempty=%b, expected 1", rdempty);
    end
  endtask

  // Three pushes prime the FIFO, then each cycle pushes and pops together.
  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h60 + i), (i >= 3));
      if (i >= 3) begin
        checks++;
        if (q !== 8'(8'h60 + i - 3) || usedw !== 5'd3) begin
          errors++;
          $display("[TB] FAIL wrap%0d: q=%h usedw=%0d, expected %h 3",
                   i, q, usedw, 8'(8'h60 + i - 3));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (q !== 8'(8'h60 + 37 + i) || usedw !== 5'(2 - i)) begin
        errors++;
        $display("[TB] FAIL wrap_drain%0d: q=%h usedw=%0d, expected %h %0d",
                 i, q, usedw, 8'(8'h60 + 37 + i), 2 - i);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Single-clock, synchronous first-in first-out byte buffer that decouples a UART transmit/receive engine from the CPU-side bus.
- The producer pushes bytes with wrreq; the consumer pops them with rdreq.
- q is a registered output, valid the cycle after a successful read.
- Full and empty status are exposed so the producer and consumer can throttle.

Parameters:
DATA_W, 8, width of each stored word in bits.
DEPTH, 16, number of storage entries; must be a power of two and at least 2.
AW, $clog2(DEPTH), derived address width; not to be overridden.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
wrreq  input  1  write request; the word on data is pushed when wrreq=1 and wrfull=0.
data  input  DATA_W  write data. A wider bus connected here is truncated by the instantiating parent to the low DATA_W bits.
wrfull  output  1  high when usedw == DEPTH.
rdreq  input  1  read request; the oldest word is popped when rdreq=1 and rdempty=0.
q  output  DATA_W  registered read data.
rdempty  output  1  high when usedw == 0.
usedw  output  AW+1  number of words currently stored, range 0..DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - write pointer, read pointer and usedw clear to 0;
  - q = 0, rdempty = 1, wrfull = 0.
  - Storage array contents are not reset.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Accepted write (wr_ok = wrreq & ~wrfull):
  - mem[wptr] <= data;
  - wptr increments modulo DEPTH (natural wrap at AW bits).
- Accepted read (rd_ok = rdreq & ~rdempty):
  - q <= mem[rptr];
  - rptr increments modulo DEPTH.
  - Read latency is 1 clock: q holds the popped word from the edge after the rdreq cycle.
- q holds its last value whenever rd_ok=0. There is no show-ahead: q does not reflect the head until it is popped.
- usedw: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- wrfull and rdempty are combinational decodes of the registered usedw. They reflect the new state in the cycle after the update.
- Overflow: wrreq while full is ignored; data, pointers and count are unchanged. No error flag.
- Underflow: rdreq while empty is ignored; q holds, and pointers and count are unchanged.
- Simultaneous wrreq and rdreq:
  - Not full and not empty: both are accepted and usedw is unchanged.
  - Empty: the write is accepted and the read is ignored (no fall-through); rdempty deasserts the next cycle.
  - Full: the read is accepted and the write is ignored, because wrfull gates it. usedw becomes DEPTH-1.
- Reset asserted mid-operation: all stored words are discarded immediately. The FIFO reports empty from the reset assertion onward.
- No X propagation:
  - q never takes an uninitialised memory value unless that location was written;
  - reads are only possible after a write.

Decomposition:
- No shared package is needed. DATA_W and DEPTH stay module parameters; the UART package may define UART_FIFO_DEPTH = 16 for instantiation.
- Optional sub-module: uart_fifo_ram, a simple 1-write/1-read synchronous RAM of DEPTH x DATA_W with a registered read port.
- Pointer and count control stays in uart_fifo.

Test Plan:
- Reset, then idle: rdempty=1, wrfull=0, usedw=0, q=0. Assert rst_n low mid-cycle and check the outputs change without waiting for clk.
- Write 0x41, 0x42, 0x43 on consecutive cycles, then rdreq for 3 cycles:
  - q = 0x41, 0x42, 0x43 on the three edges following each rdreq;
  - usedw goes 1,2,3 then 2,1,0;
  - rdempty=1 at the end.
- Fill DEPTH=16 words 0x00..0x0F:
  - wrfull=1 and usedw=16;
  - a 17th write of 0xFF is dropped;
  - draining yields 0x00..0x0F, never 0xFF.
- Read while empty: with q=0x0F held, rdreq for 2 cycles leaves q=0x0F, usedw=0 and rptr unchanged. A following write of 0x55 then a read returns 0x55.
- Simultaneous wrreq and rdreq:
  - at usedw=5: usedw stays 5 and order is preserved;
  - at empty: usedw becomes 1 and q is unchanged;
  - at full: usedw becomes 15, the head word appears on q, and the incoming word is dropped.
- Wrap-around: perform 40 interleaved pushes and pops of an incrementing byte pattern. The popped sequence equals the pushed sequence with no loss or duplication across pointer wrap.
